// File: rtl/mic1_mmio_console.sv
// mic1_mmio_console: memory-mapped character I/O between the mic1 data port
// and main_memory. NUM_CH channels, each with an RX FIFO (external -> CPU),
// a TX FIFO (CPU -> external) and a status register with sticky error flags.
// Channel k: DATA at IO_BASE-2k, STATUS at IO_BASE-2k-1; all other addresses
// pass through to main_memory.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   run                        CPU strobes are ignored while low
//   mem_read/mem_write         core strobes; mem_addr/mem_wdata/mem_rdata
//   mem_read_mem/mem_write_mem strobes forwarded to main_memory (0 on I/O hit)
//   mem_rdata_mem              main_memory read data
//   rx_data/rx_valid/rx_ready  per-channel inbound stream
//   tx_data/tx_valid/tx_ready  per-channel outbound stream
module mic1_mmio_console #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CHAR_W     = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFFFFFD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic [31:0]              mem_rdata,
  output logic                     mem_read_mem,
  output logic                     mem_write_mem,
  input  logic [31:0]              mem_rdata_mem,
  input  logic [NUM_CH*CHAR_W-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_valid,
  output logic [NUM_CH-1:0]        rx_ready,
  output logic [NUM_CH*CHAR_W-1:0] tx_data,
  output logic [NUM_CH-1:0]        tx_valid,
  input  logic [NUM_CH-1:0]        tx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic              rd_en, wr_en, io_hit;
  logic [NUM_CH-1:0] data_hit, stat_hit;
  logic [NUM_CH-1:0] rx_full, rx_empty, tx_full, tx_empty;
  logic [NUM_CH-1:0] rx_push, rx_pop, tx_push, tx_pop;
  logic [NUM_CH-1:0] rx_ovf, tx_drop;

  logic [AW-1:0]     rx_wptr [NUM_CH];
  logic [AW-1:0]     rx_rptr [NUM_CH];
  logic [AW-1:0]     tx_wptr [NUM_CH];
  logic [AW-1:0]     tx_rptr [NUM_CH];
  logic [CW-1:0]     rx_count [NUM_CH];
  logic [CW-1:0]     tx_count [NUM_CH];
  logic [CHAR_W-1:0] rx_mem [NUM_CH][FIFO_DEPTH];
  logic [CHAR_W-1:0] tx_mem [NUM_CH][FIFO_DEPTH];

  logic              io_sel_q;
  logic [31:0]       io_rdata_q, io_rdata;

  // Only the low CHAR_W bits of write data are stored.
  logic unused_wdata;
  assign unused_wdata = ^mem_wdata;

  // A simultaneous write wins; the read is dropped.
  assign rd_en = run & mem_read & ~mem_write;
  assign wr_en = run & mem_write;

  always_comb begin
    data_hit = '0;
    stat_hit = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      data_hit[k] = (mem_addr == IO_BASE - 32'(2 * k));
      stat_hit[k] = (mem_addr == IO_BASE - 32'(2 * k + 1));
    end
  end

  assign io_hit        = |{data_hit, stat_hit};
  assign mem_read_mem  = mem_read  & ~io_hit;
  assign mem_write_mem = mem_write & ~io_hit;
  assign mem_rdata     = io_sel_q ? io_rdata_q : mem_rdata_mem;

  always_comb begin
    tx_data  = '0;
    io_rdata = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rx_full[k]  = (rx_count[k] == CW'(FIFO_DEPTH));
      rx_empty[k] = (rx_count[k] == '0);
      tx_full[k]  = (tx_count[k] == CW'(FIFO_DEPTH));
      tx_empty[k] = (tx_count[k] == '0);
      // Fullness is the registered count: a same-cycle CPU pop does not
      // open room for an incoming character.
      rx_push[k]  = rx_valid[k] & ~rx_full[k];
      rx_pop[k]   = rd_en & data_hit[k] & ~rx_empty[k];
      tx_push[k]  = wr_en & data_hit[k] & ~tx_full[k];
      tx_pop[k]   = tx_ready[k] & ~tx_empty[k];
      tx_data[k*CHAR_W +: CHAR_W] = tx_mem[k][tx_rptr[k]];
      if (data_hit[k] && !rx_empty[k])
        io_rdata = 32'(rx_mem[k][rx_rptr[k]]);
      if (stat_hit[k])
        io_rdata = {28'b0, tx_drop[k], rx_ovf[k], tx_full[k], ~rx_empty[k]};
    end
  end

  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
      rx_ovf     <= '0;
      tx_drop    <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        rx_wptr[k]  <= '0;
        rx_rptr[k]  <= '0;
        tx_wptr[k]  <= '0;
        tx_rptr[k]  <= '0;
        rx_count[k] <= '0;
        tx_count[k] <= '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
          rx_mem[k][i] <= '0;
          tx_mem[k][i] <= '0;
        end
      end
    end else begin
      io_sel_q   <= rd_en & io_hit;
      io_rdata_q <= io_rdata;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (rx_push[k]) begin
          rx_mem[k][rx_wptr[k]] <= rx_data[k*CHAR_W +: CHAR_W];
          rx_wptr[k]            <= rx_wptr[k] + AW'(1);
        end
        if (rx_pop[k])
          rx_rptr[k] <= rx_rptr[k] + AW'(1);
        rx_count[k] <= rx_count[k] + CW'(rx_push[k]) - CW'(rx_pop[k]);

        if (tx_push[k]) begin
          tx_mem[k][tx_wptr[k]] <= mem_wdata[CHAR_W-1:0];
          tx_wptr[k]            <= tx_wptr[k] + AW'(1);
        end
        if (tx_pop[k])
          tx_rptr[k] <= tx_rptr[k] + AW'(1);
        tx_count[k] <= tx_count[k] + CW'(tx_push[k]) - CW'(tx_pop[k]);

        // Sticky flags: a set in the same cycle as a STATUS read survives.
        rx_ovf[k]  <= (rx_valid[k] & rx_full[k]) |
                      (rx_ovf[k] & ~(rd_en & stat_hit[k]));
        tx_drop[k] <= (wr_en & data_hit[k] & tx_full[k]) |
                      (tx_drop[k] & ~(rd_en & stat_hit[k]));
      end
    end
  end

endmodule

// File: tb/tb_mic1_mmio_console.sv
// Self-checking bench for mic1_mmio_console: directed scenarios plus a
// randomized run, all compared against a queue-based model of the channels.
module tb_mic1_mmio_console;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CHAR_W     = 8;
  localparam logic [31:0] IO_BASE    = 32'hFFFFFFFD;

  logic                     clk;
  logic                     reset;
  logic                     run;
  logic                     mem_read;
  logic                     mem_write;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;
  logic                     mem_read_mem;
  logic                     mem_write_mem;
  logic [31:0]              mem_rdata_mem;
  logic [NUM_CH*CHAR_W-1:0] rx_data;
  logic [NUM_CH-1:0]        rx_valid;
  logic [NUM_CH-1:0]        rx_ready;
  logic [NUM_CH*CHAR_W-1:0] tx_data;
  logic [NUM_CH-1:0]        tx_valid;
  logic [NUM_CH-1:0]        tx_ready;

  mic1_mmio_console #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .CHAR_W(CHAR_W), .IO_BASE(IO_BASE)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .mem_rdata_mem(mem_rdata_mem),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [7:0]  rxq [NUM_CH][$];
  logic [7:0]  txq [NUM_CH][$];
  bit          rx_ovf_m  [NUM_CH];
  bit          tx_drop_m [NUM_CH];
  bit          exp_pend;
  logic [31:0] exp_val;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] daddr(int unsigned k);
    return IO_BASE - 32'(2 * k);
  endfunction

  function automatic logic [31:0] saddr(int unsigned k);
    return IO_BASE - 32'(2 * k) - 32'd1;
  endfunction

  function automatic logic [7:0] txch(int unsigned k);
    return tx_data[k*CHAR_W +: CHAR_W];
  endfunction

  // Apply one clock's worth of the currently driven inputs to the model,
  // then advance to 1 time unit after the rising edge.
  task automatic cycle();
    int unsigned rsz [NUM_CH];
    int unsigned tsz [NUM_CH];
    logic [7:0]  c;
    exp_pend = 1'b0;
    exp_val  = '0;
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        rxq[k].delete();
        txq[k].delete();
        rx_ovf_m[k]  = 1'b0;
        tx_drop_m[k] = 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        rsz[k] = rxq[k].size();
        tsz[k] = txq[k].size();
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (run && mem_read && !mem_write) begin
          if (mem_addr == daddr(k)) begin
            exp_pend = 1'b1;
            if (rsz[k] > 0) exp_val = {24'b0, rxq[k].pop_front()};
          end
          if (mem_addr == saddr(k)) begin
            exp_pend = 1'b1;
            exp_val  = {28'b0, tx_drop_m[k], rx_ovf_m[k],
                        tsz[k] == FIFO_DEPTH, rsz[k] != 0};
            rx_ovf_m[k]  = 1'b0;
            tx_drop_m[k] = 1'b0;
          end
        end
        if (rx_valid[k]) begin
          if (rsz[k] == FIFO_DEPTH) rx_ovf_m[k] = 1'b1;
          else rxq[k].push_back(rx_data[k*CHAR_W +: CHAR_W]);
        end
        if (tx_ready[k] && tsz[k] > 0) c = txq[k].pop_front();
        if (run && mem_write && mem_addr == daddr(k)) begin
          if (tsz[k] < FIFO_DEPTH) txq[k].push_back(mem_wdata[7:0]);
          else tx_drop_m[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    mem_read = 1'b1; mem_addr = a;
    cycle();
    mem_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; mem_addr = a; mem_wdata = d;
    cycle();
    mem_write = 1'b0;
  endtask

  task automatic do_rx(input int unsigned k, input logic [7:0] c);
    rx_valid[k] = 1'b1;
    rx_data[k*CHAR_W +: CHAR_W] = c;
    cycle();
    rx_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_rdata_mem = 32'hDEADBEEF;
    cycle(); cycle();
    reset = 1'b0;
    checks++;
    if (rx_ready !== 2'b11) begin
      failures++; $display("FAIL reset_rx_ready got=%b exp=11", rx_ready);
    end
    checks++;
    if (tx_valid !== 2'b00 || tx_data !== '0) begin
      failures++; $display("FAIL reset_tx got valid=%b data=%h exp 0/0", tx_valid, tx_data);
    end
    checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL reset_rdata got=%h exp=deadbeef", mem_rdata);
    end
    do_read(32'hFFFFFFFC);
    checks++;
    if (mem_rdata !== 32'h0 || exp_val !== 32'h0) begin
      failures++; $display("FAIL reset_status got=%h exp=00000000", mem_rdata);
    end
  endtask

  task automatic test_rx_order();
    logic [7:0] lit [4];
    lit = '{8'h33, 8'h34, 8'h0A, 8'h00};
    do_rx(0, 8'h33); do_rx(0, 8'h34); do_rx(0, 8'h0A);
    for (int i = 0; i < 4; i++) begin
      do_read(32'hFFFFFFFD);
      checks++;
      if (mem_rdata !== {24'b0, lit[i]} || mem_rdata !== exp_val) begin
        failures++;
        $display("FAIL rx_order rd%0d got=%h exp=%h", i, mem_rdata, lit[i]);
      end
    end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 5; i++) begin
      do_rx(1, 8'h41 + 8'(i));
      if (i == 3) begin
        checks++;
        if (rx_ready[1] !== 1'b0) begin
          failures++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready[1]);
        end
      end
    end
    do_read(32'hFFFFFFFA);
    checks++;
    if (mem_rdata !== 32'h5) begin
      failures++; $display("FAIL rx_ovf_status1 got=%h exp=5", mem_rdata);
    end
    do_read(32'hFFFFFFFA);
    checks++;
    if (mem_rdata !== 32'h1) begin
      failures++; $display("FAIL rx_ovf_status2 got=%h exp=1", mem_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      do_read(32'hFFFFFFFB);
      checks++;
      if (mem_rdata !== ((i < 4) ? 32'h41 + 32'(i) : 32'h0) || mem_rdata !== exp_val) begin
        failures++; $display("FAIL rx_ovf_drain rd%0d got=%h exp=%h", i, mem_rdata, exp_val);
      end
    end
  endtask

  task automatic test_tx();
    tx_ready = '0;
    do_write(32'hFFFFFFFB, 32'h35);
    do_write(32'hFFFFFFFB, 32'h36);
    checks++;
    if (tx_valid[1] !== 1'b1 || txch(1) !== 8'h35) begin
      failures++; $display("FAIL tx_head got valid=%b data=%h exp 1/35", tx_valid[1], txch(1));
    end
    tx_ready[1] = 1'b1;
    cycle();
    checks++;
    if (tx_valid[1] !== 1'b1 || txch(1) !== 8'h36) begin
      failures++; $display("FAIL tx_second got valid=%b data=%h exp 1/36", tx_valid[1], txch(1));
    end
    cycle();
    tx_ready[1] = 1'b0;
    checks++;
    if (tx_valid[1] !== 1'b0) begin
      failures++; $display("FAIL tx_empty got valid=%b exp=0", tx_valid[1]);
    end
  endtask

  task automatic test_tx_drop();
    logic [7:0] seen [$];
    tx_ready = '0;
    for (int i = 0; i < 4; i++) do_write(32'hFFFFFFFD, 32'h11 + 32'(i));
    do_write(32'hFFFFFFFD, 32'h99);
    do_read(32'hFFFFFFFC);
    checks++;
    if (mem_rdata !== 32'hA || mem_rdata !== exp_val) begin
      failures++; $display("FAIL tx_drop_status got=%h exp=0000000a", mem_rdata);
    end
    tx_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (tx_valid[0]) seen.push_back(txch(0));
      cycle();
    end
    tx_ready[0] = 1'b0;
    checks++;
    if (seen.size() != 4) begin
      failures++; $display("FAIL tx_drop_count got=%0d exp=4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== 8'h11 + 8'(i)) begin
          failures++; $display("FAIL tx_drop_seq idx%0d got=%h exp=%h", i, seen[i], 8'h11 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_passthrough();
    mem_addr = 32'h50; mem_read = 1'b1; mem_rdata_mem = 32'h12345678;
    #1;
    checks++;
    if (mem_read_mem !== 1'b1 || mem_write_mem !== 1'b0) begin
      failures++; $display("FAIL pass_rd_strobe got=%b%b exp=10", mem_read_mem, mem_write_mem);
    end
    cycle();
    mem_read = 1'b0;
    checks++;
    if (mem_rdata !== 32'h12345678) begin
      failures++; $display("FAIL pass_rdata got=%h exp=12345678", mem_rdata);
    end
    mem_write = 1'b1; mem_wdata = 32'hAA;
    #1;
    checks++;
    if (mem_write_mem !== 1'b1 || mem_read_mem !== 1'b0) begin
      failures++; $display("FAIL pass_wr_strobe got=%b%b exp=01", mem_read_mem, mem_write_mem);
    end
    cycle();
    mem_write = 1'b0;
    mem_addr = 32'hFFFFFFFD; mem_read = 1'b1;
    #1;
    checks++;
    if (mem_read_mem !== 1'b0) begin
      failures++; $display("FAIL io_no_forward got=%b exp=0", mem_read_mem);
    end
    mem_read = 1'b0;
    do_rx(0, 8'h77);
    run = 1'b0;
    do_read(32'hFFFFFFFD);
    run = 1'b1;
    checks++;
    if (mem_rdata !== mem_rdata_mem) begin
      failures++; $display("FAIL norun_rdata got=%h exp=%h", mem_rdata, mem_rdata_mem);
    end
    do_read(32'hFFFFFFFD);
    checks++;
    if (mem_rdata !== 32'h77) begin
      failures++; $display("FAIL norun_kept got=%h exp=00000077", mem_rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_rx(0, 8'h5A);
    do_write(32'hFFFFFFFB, 32'h66);
    mem_read = 1'b1; mem_addr = 32'hFFFFFFFD; reset = 1'b1; mem_rdata_mem = 32'hCAFE0001;
    cycle();
    mem_read = 1'b0; reset = 1'b0;
    checks++;
    if (mem_rdata !== 32'hCAFE0001) begin
      failures++; $display("FAIL midreset_rdata got=%h exp=cafe0001", mem_rdata);
    end
    checks++;
    if (rx_ready !== 2'b11 || tx_valid !== 2'b00 || tx_data !== '0) begin
      failures++;
      $display("FAIL midreset_state got rdy=%b val=%b data=%h exp 11/00/0", rx_ready, tx_valid, tx_data);
    end
    do_read(32'hFFFFFFFD);
    checks++;
    if (mem_rdata !== 32'h0) begin
      failures++; $display("FAIL midreset_empty got=%h exp=0", mem_rdata);
    end
  endtask

  task automatic test_random();
    int unsigned sel, rxb, txb;
    logic [31:0] e;
    for (int n = 0; n < 600; n++) begin
      rxb = ((n / 100) % 2 == 0) ? 70 : 25;
      txb = ((n / 100) % 3 == 0) ? 20 : 60;
      sel = $urandom_range(0, 5);
      if (sel < 4) mem_addr = (sel[0]) ? saddr(sel >> 1) : daddr(sel >> 1);
      else if (sel == 4) mem_addr = 32'h50;
      else mem_addr = $urandom;
      run           = ($urandom_range(0, 9) != 0);
      mem_read      = ($urandom_range(0, 1) == 1);
      mem_write     = ($urandom_range(0, 3) == 0);
      mem_wdata     = $urandom;
      mem_rdata_mem = $urandom;
      for (int k = 0; k < NUM_CH; k++) begin
        rx_valid[k] = ($urandom_range(0, 99) < rxb);
        tx_ready[k] = ($urandom_range(0, 99) < txb);
        rx_data[k*CHAR_W +: CHAR_W] = 8'($urandom);
      end
      cycle();
      e = exp_pend ? exp_val : mem_rdata_mem;
      checks++;
      if (mem_rdata !== e) begin
        failures++; $display("FAIL rand_rdata cyc%0d got=%h exp=%h", n, mem_rdata, e);
      end
      for (int k = 0; k < NUM_CH; k++) begin
        checks++;
        if (rx_ready[k] !== (rxq[k].size() < FIFO_DEPTH) ||
            tx_valid[k] !== (txq[k].size() > 0)) begin
          failures++;
          $display("FAIL rand_flags cyc%0d ch%0d got rdy=%b val=%b exp rdy=%b val=%b", n, k,
                   rx_ready[k], tx_valid[k], rxq[k].size() < FIFO_DEPTH, txq[k].size() > 0);
        end
        if (txq[k].size() > 0) begin
          checks++;
          if (txch(k) !== txq[k][0]) begin
            failures++; $display("FAIL rand_txdata cyc%0d ch%0d got=%h exp=%h", n, k, txch(k), txq[k][0]);
          end
        end
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; rx_valid = '0; tx_ready = '0; run = 1'b1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_rdata_mem = '0;
    rx_data = '0; rx_valid = '0; tx_ready = '0;
    test_reset();
    test_rx_order();
    test_rx_overflow();
    test_tx();
    test_tx_drop();
    test_passthrough();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
